// File: rtl/kyber_keygen_seq.sv
// Sequential Kyber-style key generation core: t = A*s + e over Z_Q[x]/(x^N+1).
// Streams A, s and e in; computes one MAC per cycle; streams t out reduced to [0,Q-1].
module kyber_keygen_seq #(
  parameter int K = 2,
  parameter int N = 4,
  parameter int Q = 17,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  localparam int KN  = K * N;
  localparam int AN  = K * K * N;
  localparam int TOT = AN + 2 * KN;
  localparam int IW  = $clog2(TOT);
  localparam int RW  = (KN > 1) ? $clog2(KN) : 1;
  localparam int CW  = $clog2(KN) + 1;
  localparam int AW  = 2 * W + $clog2(KN);
  localparam logic signed [AW-1:0] QS = AW'(Q);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, FINAL, OUT} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         ld_q, ld_d;
  logic [CW-1:0]         i_q, i_d, j_q, j_d, k_q, k_d, m_q, m_d;
  logic [RW-1:0]         oc_q, oc_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [W-1:0]          mem_q [TOT];
  logic [W-1:0]          mem_d [TOT];
  logic [W-1:0]          res_q [KN];
  logic [W-1:0]          res_d [KN];
  logic                  done_q, done_d;

  logic signed [W-1:0]   a_v, s_v, e_v;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  term, sum, rem;
  int                    s_off;

  // Input buffer layout: A[i][j][m], then s[j][m], then e[i][k].
  always_comb begin
    s_off = (m_q > k_q) ? int'(k_q) + N - int'(m_q) : int'(k_q) - int'(m_q);
    a_v   = mem_q[IW'((int'(i_q) * K + int'(j_q)) * N + int'(m_q))];
    s_v   = mem_q[IW'(AN + int'(j_q) * N + s_off)];
    e_v   = mem_q[IW'(AN + KN + int'(i_q) * N + int'(k_q))];
    prod  = a_v * s_v;
    // x^N = -1: a wrapped term lands with negated sign
    term  = (m_q > k_q) ? -AW'(prod) : AW'(prod);
    sum   = acc_q + AW'(e_v);
    rem   = sum % QS;
    if (rem < 0) rem = rem + QS;
  end

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    m_d     = m_q;
    oc_d    = oc_q;
    acc_d   = acc_q;
    mem_d   = mem_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        ld_d    = '0;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        m_d     = '0;
        oc_d    = '0;
        acc_d   = '0;
      end
      LOAD: if (in_valid) begin
        mem_d[ld_q] = in_data;
        if (ld_q == IW'(TOT - 1)) begin
          state_d = MAC;
          ld_d    = '0;
        end else begin
          ld_d = ld_q + 1'b1;
        end
      end
      MAC: begin
        acc_d = acc_q + term;
        if (m_q == CW'(N - 1)) begin
          m_d = '0;
          if (j_q == CW'(K - 1)) begin
            j_d     = '0;
            state_d = FINAL;
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          m_d = m_q + 1'b1;
        end
      end
      FINAL: begin
        res_d[RW'(int'(i_q) * N + int'(k_q))] = W'(rem);
        acc_d   = '0;
        state_d = MAC;
        if (k_q == CW'(N - 1)) begin
          k_d = '0;
          if (i_q == CW'(K - 1)) begin
            i_d     = '0;
            state_d = OUT;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      OUT: if (out_ready) begin
        if (oc_q == RW'(KN - 1)) begin
          state_d = IDLE;
          oc_d    = '0;
          done_d  = 1'b1;
        end else begin
          oc_d = oc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ld_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      m_q     <= '0;
      oc_q    <= '0;
      acc_q   <= '0;
      mem_q   <= '{default: '0};
      res_q   <= '{default: '0};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      m_q     <= m_d;
      oc_q    <= oc_d;
      acc_q   <= acc_d;
      mem_q   <= mem_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == OUT);
  assign out_data  = out_valid ? res_q[oc_q] : '0;
endmodule

// File: tb/tb_kyber_keygen_seq.sv
// Bench for kyber_keygen_seq: vector table plus scoreboard on a default instance,
// and a K=3/N=8/Q=3329 instance checked against a polynomial reference model.
module tb_kyber_keygen_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start, busy, done, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic         b_start, b_busy, b_done, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [W-1:0] b_in_data, b_out_data;

  kyber_keygen_seq #(.K(2), .N(4), .Q(17), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

  kyber_keygen_seq #(.K(3), .N(8), .Q(3329), .W(W)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint md(input longint x, input int q);
    return ((x % q) + q) % q;
  endfunction

  // Full product over all (m,n) pairs, folding degree >= N back with a sign flip.
  function automatic int ref_t(input int kk, input int nn, input int q, input longint d[],
                               input int i, input int k);
    longint acc, p;
    int an;
    acc = 0;
    an  = kk * kk * nn;
    for (int j = 0; j < kk; j++)
      for (int m = 0; m < nn; m++)
        for (int n = 0; n < nn; n++)
          if ((m + n) % nn == k) begin
            p = (md(d[(i * kk + j) * nn + m], q) * md(d[an + j * nn + n], q)) % q;
            acc += (m + n >= nn) ? -p : p;
          end
    acc += d[an + kk * nn + i * nn + k];
    return int'(md(acc, q));
  endfunction

  // Scoreboards
  int           q_exp[$];
  int           qb[$];
  int           n_out = 0, n_done = 0, b_n_out = 0;
  bit           stall_prev = 1'b0;
  logic [W-1:0] data_prev;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (done) n_done++;
      if (out_valid && stall_prev) chk("out_hold", out_data, data_prev);
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) chk("unexpected_out", out_data, -1);
        else chk("out_data", out_data, q_exp.pop_front());
        chk("out_range", longint'(out_data < 17), 1);
        n_out++;
      end
      stall_prev = out_valid && !out_ready;
      data_prev  = out_data;
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_out", b_out_data, -1);
      else chk("b_out_data", b_out_data, qb.pop_front());
      chk("b_out_range", longint'(b_out_data < 3329), 1);
      b_n_out++;
    end
  end

  // mode bit0: random in_valid gaps, bit1: out_ready stall, bit2: stray start pulses
  task automatic run_job(input longint din[32], input int exp[8], input int mode);
    int cyc, busy_low, t_out, nd0, no0;
    bit stalled, got;
    foreach (exp[x]) q_exp.push_back(exp[x]);
    nd0 = n_done; no0 = n_out;
    cyc = 0; busy_low = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    foreach (din[b]) begin
      if (mode[0]) repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk); #1; cyc++;
        if (!busy) busy_low++;
      end
      in_valid = 1'b1;
      in_data  = din[b][W-1:0];
      got = 1'b0;
      for (int g = 0; g < 100 && !got; g++) begin
        @(negedge clk); got = in_ready;
        @(posedge clk); #1; cyc++;
        if (!busy) busy_low++;
      end
      chk("load_accept", got, 1);
    end
    in_valid = 1'b0;
    if (mode == 0) chk("load_cycles", cyc, 32);
    t_out = -1; stalled = 1'b0; got = 1'b0;
    for (int g = 0; g < 3000 && !got; g++) begin
      if (out_valid && t_out < 0) t_out = cyc;
      if (mode[1] && !stalled && n_out - no0 == 3) begin
        out_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; cyc++; end
        out_ready = 1'b1;
        stalled = 1'b1;
      end
      start = mode[2] && (cyc == 60 || (t_out >= 0 && cyc == t_out + 4));
      @(posedge clk); #1; cyc++;
      if (done) got = 1'b1;
      else if (!busy) busy_low++;
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    if (mode == 0) begin
      chk("compute_cycles", t_out - 32, 72);
      chk("out_cycles", cyc - t_out, 8);
    end
    chk("busy_high", busy_low, 0);
    chk("busy_at_done", busy, 0);
    chk("queue_empty", q_exp.size(), 0);
    @(posedge clk); #1;
    chk("done_width", done, 0);
    chk("single_done", n_done - nd0, 1);
    chk("no_restart", busy, 0);
  endtask

  typedef struct {
    longint din[32];
    int     exp[8];
    int     mode;
  } vec_t;

  vec_t   vecs[4];
  longint d[];
  longint bd[];
  bit     got;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    vecs[0].din = '{11, 16, 16, 6,  3, 6, 4, 9,  1, 10, 3, 5,  15, 9, 1, 6,
                    0, 1, -1, -1,   0, -1, 0, -1,
                    0, 0, 1, 0,     0, -1, 1, 0};
    vecs[0].exp  = '{7, 0, 15, 16, 6, 11, 12, 10};
    vecs[0].mode = 0;
    vecs[1]      = vecs[0];
    vecs[1].mode = 3;
    for (int x = 0; x < 32; x++) vecs[2].din[x] = longint'($urandom_range(0, 2000)) - 1000;
    vecs[2].mode = 4;
    for (int x = 0; x < 16; x++) vecs[3].din[x] = x[0] ? -64'sd2147483648 : 64'sd2147483647;
    for (int x = 16; x < 24; x++) vecs[3].din[x] = -64'sd2147483648;
    for (int x = 24; x < 32; x++) vecs[3].din[x] = longint'($urandom_range(0, 4)) - 2;
    vecs[3].mode = 1;
    for (int v = 2; v < 4; v++) begin
      d = new[32];
      foreach (d[x]) d[x] = vecs[v].din[x];
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 4; k++) vecs[v].exp[i * 4 + k] = ref_t(2, 4, 17, d, i, k);
    end

    for (int v = 0; v < 4; v++) run_job(vecs[v].din, vecs[v].exp, vecs[v].mode);

    // Reset part-way through loading, then a clean rerun
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 10; b++) begin
      in_valid = 1'b1;
      in_data  = vecs[0].din[b][W-1:0];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_job(vecs[0].din, vecs[0].exp, 0);

    // Larger parameter set against the reference model
    bd = new[120];
    for (int x = 0; x < 72; x++) bd[x] = longint'($urandom_range(0, 3328));
    for (int x = 72; x < 120; x++) bd[x] = longint'($urandom_range(0, 4)) - 2;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 8; k++) qb.push_back(ref_t(3, 8, 3329, bd, i, k));
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int b = 0; b < 120; b++) begin
      b_in_valid = 1'b1;
      b_in_data  = bd[b][W-1:0];
      got = 1'b0;
      for (int g = 0; g < 100 && !got; g++) begin
        @(negedge clk); got = b_in_ready;
        @(posedge clk); #1;
      end
      chk("b_load_accept", got, 1);
    end
    b_in_valid = 1'b0;
    got = 1'b0;
    for (int g = 0; g < 2000 && !got; g++) begin
      @(posedge clk); #1;
      got = b_done;
    end
    chk("b_done_seen", got, 1);
    chk("b_queue_empty", qb.size(), 0);
    chk("b_outputs", b_n_out, 24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/kyber_keygen_seq.md
KYBER_KEYGEN_SEQ -- requirements
Module: kyber_keygen_seq

Interface
REQ-001 SHALL have parameter K, default 2: module rank (polynomials per vector; A is KxK).
REQ-002 SHALL have parameter N, default 4: coefficients per polynomial; ring is Z_Q[x]/(x^N+1).
REQ-003 SHALL have parameter Q, default 17: modulus; 2 <= Q < 2^(W-1).
REQ-004 SHALL have parameter W, default 32: signed coefficient width on all data ports.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a key generation.
REQ-008 SHALL have port busy  output  1  high from accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last output beat is accepted.
REQ-010 SHALL have port in_valid  input  1  input coefficient beat valid.
REQ-011 SHALL have port in_ready  output  1  block accepts an input beat.
REQ-012 SHALL have port in_data  input  W  signed coefficient (A, then s, then e).
REQ-013 SHALL have port out_valid  output  1  result coefficient beat valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts a result beat.
REQ-015 SHALL have port out_data  output  W  result coefficient t, range [0,Q-1].

Function
REQ-016 SHALL implement FSM IDLE -> LOAD -> MAC -> FINAL -> (MAC | OUT) -> IDLE.
REQ-017 SHALL leave IDLE only on start=1; start in any other state SHALL be ignored.
REQ-018 SHALL in LOAD assert in_ready; a beat transfers when in_valid & in_ready.
REQ-019 SHALL load K*K*N A beats (order i, j, m; m = power of x), then K*N s beats (j, m), then K*N e beats (i, k); on the last e beat move to MAC. No beat is accepted outside LOAD.
REQ-020 SHALL compute t[i] = (sum over j of A[i][j]*s[j] mod x^N+1) + e[i], reduced to [0,Q-1].
REQ-021 SHALL in MAC perform one multiply-accumulate per cycle for coefficient t[i][k], iterating j then m over K*N cycles: term = A[i][j][m]*s[j][(k-m) mod N], negated when m > k (negacyclic wrap).
REQ-022 SHALL use a signed accumulator of 2W+clog2(K*N) bits, cleared at the start of each coefficient; no intermediate truncation.
REQ-023 SHALL in FINAL (one cycle) compute r = (acc + e[i][k]) mod Q, corrected to non-negative, store r in result buffer, advance k then i; return to MAC unless last coefficient, else OUT.
REQ-024 SHALL take K*N*(K*N+1) cycles from entering MAC to entering OUT (72 at defaults).
REQ-025 SHALL in OUT present t in order i, k with out_valid=1; advance on out_valid & out_ready; out_data SHALL hold stable while out_ready=0.
REQ-026 SHALL pulse done for one cycle and return to IDLE in the cycle after the K*N-th output transfer; busy falls in the same cycle.
REQ-027 SHALL stall LOAD indefinitely on in_valid=0 and OUT indefinitely on out_ready=0, with no state loss.
REQ-028 SHALL use input values as signed two's complement without pre-reduction; result SHALL be in [0,Q-1] for any inputs.
REQ-029 SHALL accept a new start in the cycle after done (back-to-back operation).

Reset
REQ-030 SHALL on rst=1 enter IDLE and drive busy=0, done=0, in_ready=0, out_valid=0, out_data=0, clear all counters and accumulator; rst has priority over start and any handshake.
REQ-031 SHALL on rst mid-operation abandon the run; partially loaded A/s/e and results SHALL not be output.

Verification
REQ-032 SHALL verify defaults: A[0][0]=(11,16,16,6), A[0][1]=(3,6,4,9), A[1][0]=(1,10,3,5), A[1][1]=(15,9,1,6), s[0]=(0,1,-1,-1), s[1]=(0,-1,0,-1), e[0]=(0,0,1,0), e[1]=(0,-1,1,0) -> out beats 7,0,15,16,6,11,12,10, then done pulse.
REQ-033 SHALL verify throughput: continuous in_valid and out_ready -> 32 load cycles, 72 compute cycles, 8 output cycles, busy high throughout.
REQ-034 SHALL verify backpressure: random in_valid gaps and out_ready low for 5 cycles mid-OUT -> identical output sequence, out_data stable while stalled.
REQ-035 SHALL verify start pulsed during MAC and OUT -> ignored, single done, results unchanged.
REQ-036 SHALL verify rst asserted after 10 loaded beats -> busy=0, in_ready=0 next cycle; fresh start with REQ-032 data -> same REQ-032 results.
REQ-037 SHALL verify K=3, N=8, Q=3329 against a reference model with random A in [0,3328], s,e in [-2,2] -> all outputs match and lie in [0,3328].
